// File: rtl/melody_sequencer_if.sv
// Handshake bundle between the melody sequencer, the key encoder and the tone generator.
// The sequencer takes the slave side; the stimulus or upstream logic takes the master side.
interface melody_sequencer_if #(
  parameter int CODE_W = 5,
  parameter int DEPTH  = 16
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CODE_W-1:0] key_code_in;
  logic              rec_btn;
  logic              play_btn;
  logic [CODE_W-1:0] key_code_out;
  logic [1:0]        mode;
  logic [IDX_W-1:0]  step_idx;
  logic [IDX_W:0]    seq_len;

  modport master (
    output key_code_in, rec_btn, play_btn,
    input  key_code_out, mode, step_idx, seq_len
  );

  modport slave (
    input  key_code_in, rec_btn, play_btn,
    output key_code_out, mode, step_idx, seq_len
  );
endinterface

// File: rtl/melody_sequencer.sv
// Records timed key codes into a small register array and plays them back, passing live keys
// through otherwise. Define SEQ_LOOP_EN to make playback repeat until aborted.
module melody_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 12500000,
  parameter int CODE_W   = 5
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  state_t            state_r;
  logic [CODE_W-1:0] mem_r [DEPTH];
  logic [CODE_W-1:0] key_out_r;
  logic [IDX_W-1:0]  step_r;
  logic [LEN_W-1:0]  len_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              rec_prev_r;
  logic              play_prev_r;

  logic              rec_edge_s;
  logic              play_edge_s;
  logic              tick_s;
  logic              full_s;
  logic              last_s;
  logic              mem_we_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [LEN_W-1:0]  len_inc_s;
  logic [LEN_W-1:0]  step_inc_s;

  // Edge detection, step tick and next-index arithmetic shared by the state machine
  always_comb begin
    rec_edge_s  = bus.rec_btn & ~rec_prev_r;
    play_edge_s = bus.play_btn & ~play_prev_r;
    tick_s      = (cnt_r == CNT_W'(TICK_DIV - 1));
    if (tick_s) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    len_inc_s  = len_r + LEN_W'(1);
    step_inc_s = {1'b0, step_r} + LEN_W'(1);
    full_s     = (len_inc_s == LEN_W'(DEPTH));
    last_s     = (step_inc_s >= len_r);
    mem_we_s   = (state_r == ST_RECORD) & tick_s & ~rst;
  end

  // Note storage; the write address never reaches DEPTH because recording stops when full
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[len_r[IDX_W-1:0]] <= bus.key_code_in;
    end
  end

  // Mode state machine with registered outputs; any mode change restarts the step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      key_out_r   <= {CODE_W{1'b0}};
      step_r      <= {IDX_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      rec_prev_r  <= 1'b0;
      play_prev_r <= 1'b0;
    end else begin
      rec_prev_r  <= bus.rec_btn;
      play_prev_r <= bus.play_btn;
      case (state_r)
        ST_IDLE: begin
          key_out_r <= bus.key_code_in;
          if (rec_edge_s) begin
            state_r <= ST_RECORD;
            len_r   <= {LEN_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
          end else if (play_edge_s && (len_r != {LEN_W{1'b0}})) begin
            state_r   <= ST_PLAY;
            step_r    <= {IDX_W{1'b0}};
            key_out_r <= mem_r[{IDX_W{1'b0}}];
            cnt_r     <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        ST_RECORD: begin
          key_out_r <= bus.key_code_in;
          if (tick_s) begin
            len_r <= len_inc_s;
          end
          // A stop press on the storing tick still keeps that step
          if ((tick_s && full_s) || rec_edge_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        ST_PLAY: begin
          if (play_edge_s) begin
            state_r   <= ST_IDLE;
            step_r    <= {IDX_W{1'b0}};
            key_out_r <= bus.key_code_in;
            cnt_r     <= {CNT_W{1'b0}};
          end else if (tick_s && !last_s) begin
            step_r    <= step_inc_s[IDX_W-1:0];
            key_out_r <= mem_r[step_inc_s[IDX_W-1:0]];
            cnt_r     <= cnt_next_s;
          end else if (tick_s) begin
            step_r <= {IDX_W{1'b0}};
`ifdef SEQ_LOOP_EN
            key_out_r <= mem_r[{IDX_W{1'b0}}];
            cnt_r     <= cnt_next_s;
`else
            state_r   <= ST_IDLE;
            key_out_r <= bus.key_code_in;
            cnt_r     <= {CNT_W{1'b0}};
`endif
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          step_r  <= {IDX_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.key_code_out = key_out_r;
  assign bus.mode         = state_r;
  assign bus.step_idx     = step_r;
  assign bus.seq_len      = len_r;
endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios with literal expectations, then
// random buttons/keys/resets, all compared every cycle against a queue-based behavioural model.
module tb_melody_sequencer;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int CODE_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  melody_sequencer_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

  melody_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .CODE_W(CODE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // behavioural model: song is the list of recorded notes, phase counts cycles since mode entry
  int m_mode  = 0;
  int m_out   = 0;
  int m_step  = 0;
  int m_phase = 0;
  int song[$];
  bit m_prev_rec  = 1'b0;
  bit m_prev_play = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit re, pe, tick;
    int nm;
    int key;
    key = int'(bus.key_code_in);
    if (rst) begin
      m_mode = 0; m_out = 0; m_step = 0; m_phase = 0;
      song.delete();
      m_prev_rec = 1'b0; m_prev_play = 1'b0;
      return;
    end
    re = bus.rec_btn && !m_prev_rec;
    pe = bus.play_btn && !m_prev_play;
    m_prev_rec  = bus.rec_btn;
    m_prev_play = bus.play_btn;
    tick = ((m_phase % TICK_DIV) == TICK_DIV - 1);
    nm = m_mode;
    if (m_mode == 0) begin
      m_out = key;
      if (re) begin
        nm = 1;
        song.delete();
      end else if (pe && song.size() > 0) begin
        nm = 2; m_step = 0; m_out = song[0];
      end
    end else if (m_mode == 1) begin
      m_out = key;
      if (tick) begin
        song.push_back(key);
        if (song.size() == DEPTH) nm = 0;
      end
      if (re) nm = 0;
    end else begin
      if (pe) begin
        nm = 0; m_step = 0; m_out = key;
      end else if (tick) begin
        if (m_step + 1 < song.size()) begin
          m_step = m_step + 1;
          m_out = song[m_step];
        end else begin
          m_step = 0;
`ifdef SEQ_LOOP_EN
          m_out = song[0];
`else
          m_out = key;
          nm = 0;
`endif
        end
      end
    end
    m_phase = (nm != m_mode) ? 0 : m_phase + 1;
    m_mode = nm;
  endtask

  // update the model from the inputs seen at each edge, then compare once outputs settle
  always @(posedge clk) begin
    model_step();
    #1;
    chk("key_code_out", int'(bus.key_code_out), m_out);
    chk("mode", int'(bus.mode), m_mode);
    chk("step_idx", int'(bus.step_idx), m_step);
    chk("seq_len", int'(bus.seq_len), song.size());
  end

  initial begin
    bus.key_code_in = 5'd0;
    bus.rec_btn     = 1'b0;
    bus.play_btn    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // live passthrough after reset
    bus.key_code_in = 5'd7;
    @(negedge clk);
    chk("lit_live7", int'(bus.key_code_out), 7);
    chk("lit_idle_mode", int'(bus.mode), 0);
    chk("lit_idle_len", int'(bus.seq_len), 0);

    // record 3, 5, 9 then stop with rec
    bus.rec_btn = 1'b1; bus.key_code_in = 5'd3;
    @(negedge clk);
    chk("lit_rec_mode", int'(bus.mode), 1);
    bus.rec_btn = 1'b0;
    repeat (4) @(negedge clk);
    bus.key_code_in = 5'd5;
    repeat (4) @(negedge clk);
    bus.key_code_in = 5'd9;
    repeat (4) @(negedge clk);
    bus.rec_btn = 1'b1;
    @(negedge clk);
    bus.rec_btn = 1'b0;
    chk("lit_rec3_len", int'(bus.seq_len), 3);
    chk("lit_rec3_mode", int'(bus.mode), 0);

    // playback
    bus.key_code_in = 5'd11;
    bus.play_btn = 1'b1;
    @(negedge clk);
    bus.play_btn = 1'b0;
    chk("lit_play_first", int'(bus.key_code_out), 3);
    chk("lit_play_mode", int'(bus.mode), 2);
    repeat (4) @(negedge clk);
    chk("lit_play_second", int'(bus.key_code_out), 5);
    repeat (4) @(negedge clk);
    chk("lit_play_third", int'(bus.key_code_out), 9);
    chk("lit_play_step2", int'(bus.step_idx), 2);
    repeat (4) @(negedge clk);
`ifdef SEQ_LOOP_EN
    chk("lit_loop_out", int'(bus.key_code_out), 3);
    chk("lit_loop_mode", int'(bus.mode), 2);
    bus.play_btn = 1'b1;
    @(negedge clk);
    bus.play_btn = 1'b0;
    chk("lit_abort_mode", int'(bus.mode), 0);
`else
    chk("lit_end_out", int'(bus.key_code_out), 11);
    chk("lit_end_mode", int'(bus.mode), 0);
`endif

    // hold a code long enough to fill memory
    bus.rec_btn = 1'b1; bus.key_code_in = 5'd6;
    @(negedge clk);
    bus.rec_btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("lit_full_before", int'(bus.mode), 1);
    @(negedge clk);
    chk("lit_full_mode", int'(bus.mode), 0);
    chk("lit_full_len", int'(bus.seq_len), 4);

    // play with empty memory is ignored; rec beats play
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.play_btn = 1'b1;
    @(negedge clk);
    bus.play_btn = 1'b0;
    chk("lit_empty_play", int'(bus.mode), 0);
    bus.rec_btn = 1'b1; bus.play_btn = 1'b1; bus.key_code_in = 5'd1;
    @(negedge clk);
    bus.rec_btn = 1'b0; bus.play_btn = 1'b0;
    chk("lit_rec_wins", int'(bus.mode), 1);
    repeat (16) @(negedge clk);
    chk("lit_refill_len", int'(bus.seq_len), 4);

    // reset in the middle of playback
    bus.play_btn = 1'b1;
    @(negedge clk);
    bus.play_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("lit_mid_step", int'(bus.step_idx), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_mode", int'(bus.mode), 0);
    chk("lit_rst_out", int'(bus.key_code_out), 0);
    chk("lit_rst_len", int'(bus.seq_len), 0);
    chk("lit_rst_step", int'(bus.step_idx), 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.key_code_in = 5'($urandom_range(0, 31));
      bus.rec_btn     = ($urandom_range(0, 99) < 4);
      bus.play_btn    = ($urandom_range(0, 99) < 5);
      rst             = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.rec_btn = 1'b0;
    bus.play_btn = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
